// File: rtl/uart_pkg.sv
// uart_pkg: shared UART FSM encodings, parity constants and prescale clamp (PARITY state only with UART_TX_PARITY_EN)
package uart_pkg;
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } uart_state_e;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD = 1'b1;
  localparam logic [5:0] PRESCALE_MIN = 6'd4;
  function automatic logic [5:0] clamp_prescale(input logic [5:0] p);
    return (p < PRESCALE_MIN) ? PRESCALE_MIN : p;
  endfunction
endpackage

// File: rtl/uart_tx_parity_calc.sv
// uart_tx_parity_calc: combinational even/odd parity of the latched TX word
module uart_tx_parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  parity
);
  assign parity = (par_typ == PAR_ODD) ? ~^data : ^data;
endmodule

// File: rtl/uart_tx_frame_serializer.sv
// uart_tx_frame_serializer: UART TX framing start/data LSB-first/[parity]/stop; parity built only with UART_TX_PARITY_EN
module uart_tx_frame_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            tx_Prescale,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  busy
);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  uart_state_e r_state, w_next, w_after_data;
  logic [5:0] r_cnt, r_p;
  logic [BW-1:0] r_bit;
  logic [DATA_WIDTH-1:0] r_sh, w_sh_n;
  logic r_tx, r_busy, w_tx_n, w_last, w_accept, w_shift, w_bit_end;
  assign w_last = r_cnt == r_p - 6'd1;
  assign w_accept = (r_state == ST_IDLE) && Data_Valid;
  assign w_bit_end = r_bit == BW'(DATA_WIDTH - 1);
  assign w_shift = (r_state == ST_DATA) && w_last;
  assign w_sh_n = w_shift ? r_sh >> 1 : r_sh;
  assign TX_OUT = r_tx;
  assign busy = r_busy;
`ifdef UART_TX_PARITY_EN
  logic [DATA_WIDTH-1:0] r_data;
  logic r_par_en, r_par_typ, w_par;
  uart_tx_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_par (
    .data    (r_data),
    .par_typ (r_par_typ),
    .parity  (w_par)
  );
  assign w_after_data = r_par_en ? ST_PARITY : ST_STOP;
  // hold the accepted word and parity options for the whole frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data <= '0;
      r_par_en <= 1'b0;
      r_par_typ <= 1'b0;
    end else if (w_accept) begin
      r_data <= P_DATA;
      r_par_en <= PAR_EN;
      r_par_typ <= PAR_TYP;
    end
  end
`else
  logic w_unused_par;
  assign w_unused_par = PAR_EN ^ PAR_TYP;
  assign w_after_data = ST_STOP;
`endif
  // next state: each non-idle state lasts one full bit period
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   w_next = Data_Valid ? ST_START : ST_IDLE;
      ST_START:  w_next = w_last ? ST_DATA : ST_START;
      ST_DATA:   w_next = (w_last && w_bit_end) ? w_after_data : ST_DATA;
`ifdef UART_TX_PARITY_EN
      ST_PARITY: w_next = w_last ? ST_STOP : ST_PARITY;
`endif
      ST_STOP:   w_next = w_last ? ST_IDLE : ST_STOP;
      default:   w_next = ST_IDLE;
    endcase
  end
  // line level for the state being entered, so TX_OUT is registered with no input path
  always_comb begin
    w_tx_n = 1'b1;
    if (w_next == ST_START) w_tx_n = 1'b0;
    else if (w_next == ST_DATA) w_tx_n = w_sh_n[0];
`ifdef UART_TX_PARITY_EN
    else if (w_next == ST_PARITY) w_tx_n = w_par;
`endif
  end
  // FSM, bit-period counter and bit counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt <= '0;
      r_bit <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= (r_state == ST_IDLE || w_last) ? '0 : r_cnt + 6'd1;
      r_bit <= w_accept ? '0 : w_shift ? r_bit + BW'(1) : r_bit;
    end
  end
  // latch prescale and load/shift the data word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_p <= '0;
      r_sh <= '0;
    end else begin
      r_p <= w_accept ? clamp_prescale(tx_Prescale) : r_p;
      r_sh <= w_accept ? P_DATA : w_sh_n;
    end
  end
  // registered outputs, idle high and not busy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx <= 1'b1;
      r_busy <= 1'b0;
    end else begin
      r_tx <= w_tx_n;
      r_busy <= w_next != ST_IDLE;
    end
  end
endmodule

// File: tb/tb_uart_tx_frame_serializer.sv
// tb_uart_tx_frame_serializer: scoreboard bench for the UART TX serializer
module tb_uart_tx_frame_serializer;
  localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
  localparam bit PBUILT = 1'b1;
`else
  localparam bit PBUILT = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0;
  logic [5:0] tx_Prescale = '0;
  logic [DW-1:0] P_DATA = '0;
  logic Data_Valid = 1'b0, PAR_EN = 1'b0, PAR_TYP = 1'b0;
  logic TX_OUT, busy;
  typedef struct {
    int len;
    int p;
    int nb;
    logic [15:0] bits;
  } frame_t;
  frame_t exp_q[$];
  int checks = 0, errors = 0;
  int cyc = 0, frames_seen = 0, end_cyc = 0, last_gap = 0;
  logic samples[4096];

  uart_tx_frame_serializer #(.DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_Prescale (tx_Prescale),
    .P_DATA      (P_DATA),
    .Data_Valid  (Data_Valid),
    .PAR_EN      (PAR_EN),
    .PAR_TYP     (PAR_TYP),
    .TX_OUT      (TX_OUT),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic frame_t model(input logic [7:0] d, input logic [5:0] ps, input logic pe, input logic pt);
    frame_t f;
    f.p = (ps < 6'd4) ? 4 : int'(ps);
    f.bits = '0;
    for (int i = 0; i < DW; i++) f.bits[1+i] = d[i];
    f.nb = 1 + DW;
    if (pe && PBUILT) begin
      f.bits[f.nb] = pt ? ~^d : ^d;
      f.nb++;
    end
    f.bits[f.nb] = 1'b1;
    f.nb++;
    f.len = f.nb * f.p;
    return f;
  endfunction

  task automatic send(input logic [7:0] d, input logic [5:0] ps, input logic pe, input logic pt, input bit push);
    @(negedge clk);
    P_DATA = d; tx_Prescale = ps; PAR_EN = pe; PAR_TYP = pt; Data_Valid = 1'b1;
    if (push) exp_q.push_back(model(d, ps, pe, pt));
    @(posedge clk);
    #1 Data_Valid = 1'b0;
  endtask

  task automatic wait_busy(input logic val, input string tag);
    int n = 0;
    @(negedge clk);
    while (busy !== val && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check(tag, 32'(busy), 32'(val));
  endtask

  task automatic wait_frames(input int n, input string tag);
    int k = 0;
    while (frames_seen < n && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 5000) check(tag, frames_seen, n);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst && busy) begin
        int len, bad;
        logic [15:0] got;
        frame_t e;
        last_gap = cyc - end_cyc;
        len = 0;
        while (busy && len < 4000) begin
          samples[len] = TX_OUT;
          len++;
          @(negedge clk);
        end
        end_cyc = cyc;
        if (!rst) continue;
        check("idle_tx_after_frame", 32'(TX_OUT), 32'd1);
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 32'd1, 32'd0);
          continue;
        end
        e = exp_q.pop_front();
        check("frame_len", len, e.len);
        bad = 0;
        for (int k = 0; k < len && k < e.len; k++)
          if (samples[k] !== e.bits[k / e.p]) bad++;
        check("frame_bit_cycles", bad, 0);
        got = '0;
        for (int b = 0; b < e.nb && b * e.p + e.p / 2 < len; b++) got[b] = samples[b * e.p + e.p / 2];
        check("frame_bits", 32'(got), 32'(e.bits));
        frames_seen++;
      end
    end
  end

  initial begin
    // reset held with inputs toggling
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      Data_Valid = i[0]; P_DATA = 8'(i * 37); tx_Prescale = 6'(i + 3); PAR_EN = i[1];
      #1;
      if (i % 2 == 0) begin
        check("rst_tx", 32'(TX_OUT), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
      end
    end
    @(negedge clk);
    Data_Valid = 1'b0; rst = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_tx", 32'(TX_OUT), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);
    // even parity, P=8
    send(8'hA5, 6'd8, 1'b1, 1'b0, 1'b1);
    wait_frames(1, "timeout_even");
    // odd parity, P=16, inputs changed mid-frame
    send(8'hA5, 6'd16, 1'b1, 1'b1, 1'b1);
    repeat (40) @(negedge clk);
    P_DATA = 8'h00; PAR_TYP = 1'b0; PAR_EN = 1'b0; tx_Prescale = 6'd4;
    wait_frames(2, "timeout_odd");
    // back-to-back with Data_Valid held high
    @(negedge clk);
    P_DATA = 8'h01; tx_Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    exp_q.push_back(model(8'h01, 6'd8, 1'b0, 1'b0));
    wait_busy(1'b1, "timeout_b2b_start");
    P_DATA = 8'hFF;
    exp_q.push_back(model(8'hFF, 6'd8, 1'b0, 1'b0));
    wait_busy(1'b0, "timeout_b2b_fall");
    wait_busy(1'b1, "timeout_b2b_second");
    Data_Valid = 1'b0;
    wait_frames(4, "timeout_b2b");
    check("b2b_gap", last_gap, 1);
    // reset during DATA bit 3
    send(8'h55, 6'd8, 1'b0, 1'b0, 1'b0);
    repeat (34) @(posedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_tx", 32'(TX_OUT), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    send(8'h3C, 6'd8, 1'b1, 1'b0, 1'b1);
    wait_frames(5, "timeout_after_rst");
    // prescale clamp and Data_Valid ignored while busy
    send(8'h96, 6'd2, 1'b1, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    Data_Valid = 1'b1; P_DATA = 8'h11;
    @(negedge clk);
    Data_Valid = 1'b0;
    wait_frames(6, "timeout_clamp");
    repeat (30) @(negedge clk);
    check("no_queued_frame", frames_seen, 6);
    check("idle_busy", 32'(busy), 32'd0);
    send(8'h0F, 6'd0, 1'b0, 1'b1, 1'b1);
    wait_frames(7, "timeout_p0");
    send(8'hC3, 6'd63, 1'b1, 1'b1, 1'b1);
    wait_frames(8, "timeout_p63");
    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
